// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution logic of the multicycle ARM core.
// Holds the condition-code encodings, the NZCV flag bit positions and a
// packed NZCV struct so every user of the flags agrees on the layout.

package cond_pkg;

   // Condition-code encodings as they appear in Instr[31:28]
   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   // Bit positions of each flag inside a 4-bit {N,Z,C,V} vector
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Packed view of the status flags; bit order matches {N,Z,C,V}
   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } nzcv_t;

endpackage

// File: rtl/cond_check.sv
// Purely combinational ARM condition evaluator: (Cond, Flags) -> pass/fail.
// Kept as its own block so a later pipelined core can reuse it unchanged.
// The reserved 1111 encoding always evaluates to a defined 0.

module cond_check
   import cond_pkg::*;
(
   input  logic [3:0] i_cond,
   input  logic [3:0] i_flags,
   output logic       o_result
);

   nzcv_t w_flags;
   logic  w_nEqV;

   assign w_flags = nzcv_t'(i_flags);
   assign w_nEqV  = (w_flags.n == w_flags.v);

   // Decode the condition field against the supplied flags, defaulting to fail
   always_comb begin
      o_result = 1'b0;
      case (i_cond)
         COND_EQ: o_result = w_flags.z;
         COND_NE: o_result = ~w_flags.z;
         COND_CS: o_result = w_flags.c;
         COND_CC: o_result = ~w_flags.c;
         COND_MI: o_result = w_flags.n;
         COND_PL: o_result = ~w_flags.n;
         COND_VS: o_result = w_flags.v;
         COND_VC: o_result = ~w_flags.v;
         COND_HI: o_result = w_flags.c & ~w_flags.z;
         COND_LS: o_result = ~w_flags.c | w_flags.z;
         COND_GE: o_result = w_nEqV;
         COND_LT: o_result = ~w_nEqV;
         COND_GT: o_result = ~w_flags.z & w_nEqV;
         COND_LE: o_result = w_flags.z | ~w_nEqV;
         COND_AL: o_result = 1'b1;
         COND_NV: o_result = 1'b0;
         default: o_result = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution unit for the multicycle ARM core.
// Holds the NZCV flags, registers the condition result one cycle (CondExD)
// and gates PC / register-file / memory write requests so that an
// instruction whose condition fails retires without side effects.
// Optional retire counters are built only when COND_PERF_EN is defined;
// otherwise ExecCnt and SkipCnt are tied to zero.

module cond_unit
   import cond_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       Cond,
   input  logic [3:0]       ALUFlags,
   input  logic [1:0]       FlagW,
   input  logic             PCS,
   input  logic             NextPC,
   input  logic             RegW,
   input  logic             MemW,
   input  logic             IRWrite,
   output logic             PCWrite,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic [3:0]       Flags,
   output logic             CondEx,
   output logic [CNT_W-1:0] ExecCnt,
   output logic [CNT_W-1:0] SkipCnt
);

   nzcv_t r_flags;
   logic  r_condExD;
   logic  w_condResult;

   // Condition is always evaluated against the stored flags, so an
   // instruction that writes flags still sees the old ones for itself
   cond_check u_condCheck (
      .i_cond   (Cond),
      .i_flags  (r_flags),
      .o_result (w_condResult)
   );

   // Flag groups N,Z and C,V update independently and only when the condition passes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_flags <= '0;
      end else begin
         if (FlagW[1] && w_condResult) begin
            r_flags.n <= ALUFlags[FLAG_N];
            r_flags.z <= ALUFlags[FLAG_Z];
         end
         if (FlagW[0] && w_condResult) begin
            r_flags.c <= ALUFlags[FLAG_C];
            r_flags.v <= ALUFlags[FLAG_V];
         end
      end
   end

   // Condition result delayed by one cycle, sampled unconditionally every cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_condExD <= 1'b0;
      end else begin
         r_condExD <= w_condResult;
      end
   end

   // Write gating; fetch (NextPC) advances the PC regardless of the condition
   always_comb begin
      PCWrite  = (PCS & r_condExD) | NextPC;
      RegWrite = RegW & r_condExD;
      MemWrite = MemW & r_condExD;
   end

   assign Flags  = r_flags;
   assign CondEx = r_condExD;

`ifdef COND_PERF_EN
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             r_irwD;
   logic [CNT_W-1:0] r_execCnt;
   logic [CNT_W-1:0] r_skipCnt;

   // Delayed fetch strobe marks the decode cycle where each instruction is counted once
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_irwD <= 1'b0;
      end else begin
         r_irwD <= IRWrite;
      end
   end

   // Retire counters classify each instruction as executed or skipped; both wrap
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_execCnt <= '0;
         r_skipCnt <= '0;
      end else if (r_irwD) begin
         if (w_condResult) begin
            r_execCnt <= r_execCnt + CNT_ONE;
         end else begin
            r_skipCnt <= r_skipCnt + CNT_ONE;
         end
      end
   end

   assign ExecCnt = r_execCnt;
   assign SkipCnt = r_skipCnt;
`else
   logic w_unusedIrWrite;

   assign w_unusedIrWrite = IRWrite;
   assign ExecCnt         = '0;
   assign SkipCnt         = '0;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Directed testbench for cond_unit with hand-computed expected values.
// Counter checks depend on whether COND_PERF_EN is defined.

module tb_cond_unit;

   localparam int CNT_W = 32;

   logic             clk;
   logic             reset;
   logic [3:0]       Cond;
   logic [3:0]       ALUFlags;
   logic [1:0]       FlagW;
   logic             PCS;
   logic             NextPC;
   logic             RegW;
   logic             MemW;
   logic             IRWrite;
   logic             PCWrite;
   logic             RegWrite;
   logic             MemWrite;
   logic [3:0]       Flags;
   logic             CondEx;
   logic [CNT_W-1:0] ExecCnt;
   logic [CNT_W-1:0] SkipCnt;

   int errors = 0;
   int checks = 0;

   // Each entry is {flags[3:0], cond[3:0], expected CondEx}
   localparam int NVEC = 40;
   localparam logic [8:0] VECS [NVEC] = '{
      9'b0110_0000_1, 9'b0110_0001_0, 9'b0110_0010_1, 9'b0110_0011_0,
      9'b0110_0100_0, 9'b0110_0101_1, 9'b0110_0110_0, 9'b0110_0111_1,
      9'b0110_1000_0, 9'b0110_1001_1, 9'b0110_1100_0, 9'b0110_1101_1,
      9'b0010_1000_1, 9'b0010_1001_0, 9'b0010_0000_0,
      9'b1001_0100_1, 9'b1001_0110_1,
      9'b0000_1010_1, 9'b0000_1011_0, 9'b0000_1100_1, 9'b0000_1101_0,
      9'b0001_1010_0, 9'b0001_1011_1, 9'b0001_1100_0, 9'b0001_1101_1,
      9'b1000_1010_0, 9'b1000_1011_1, 9'b1000_1100_0, 9'b1000_1101_1,
      9'b1001_1010_1, 9'b1001_1011_0, 9'b1001_1100_1, 9'b1001_1101_0,
      9'b1100_1010_0, 9'b1100_1011_1, 9'b1100_1100_0, 9'b1100_1101_1,
      9'b0000_1111_0, 9'b1111_1111_0, 9'b0000_1110_1
   };

   cond_unit #(.CNT_W(CNT_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .Cond     (Cond),
      .ALUFlags (ALUFlags),
      .FlagW    (FlagW),
      .PCS      (PCS),
      .NextPC   (NextPC),
      .RegW     (RegW),
      .MemW     (MemW),
      .IRWrite  (IRWrite),
      .PCWrite  (PCWrite),
      .RegWrite (RegWrite),
      .MemWrite (MemWrite),
      .Flags    (Flags),
      .CondEx   (CondEx),
      .ExecCnt  (ExecCnt),
      .SkipCnt  (SkipCnt)
   );

   // Free-running 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Drive condition, ALU flags and flag-write request, then advance one cycle
   task automatic applyStimulus(input logic [3:0] c, input logic [3:0] af, input logic [1:0] fw);
      Cond     = c;
      ALUFlags = af;
      FlagW    = fw;
      tick();
   endtask

   task automatic loadFlags(input logic [3:0] f);
      applyStimulus(4'b1110, f, 2'b11);
      FlagW = 2'b00;
   endtask

   task automatic fetchInstr(input logic [3:0] c);
      IRWrite = 1'b1;
      Cond    = c;
      tick();
      IRWrite = 1'b0;
      tick();
   endtask

   initial begin
      reset    = 1'b0;
      Cond     = 4'b1110;
      ALUFlags = 4'b1111;
      FlagW    = 2'b11;
      PCS      = 1'b1;
      NextPC   = 1'b0;
      RegW     = 1'b1;
      MemW     = 1'b1;
      IRWrite  = 1'b0;

      // Reset holds state clear despite active flag writes
      tick();
      tick();
      checkOutput("rst_flags", Flags, 32'h0);
      checkOutput("rst_condex", CondEx, 32'h0);
      checkOutput("rst_pcwrite", PCWrite, 32'h0);
      checkOutput("rst_regwrite", RegWrite, 32'h0);
      checkOutput("rst_memwrite", MemWrite, 32'h0);
      checkOutput("rst_exec", ExecCnt, 32'h0);
      checkOutput("rst_skip", SkipCnt, 32'h0);

      FlagW = 2'b00;
      ALUFlags = 4'b0000;
      PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;
      reset = 1'b1;
      tick();
      checkOutput("rel_condex", CondEx, 32'h1);
      checkOutput("rel_flags", Flags, 32'h0);

      // Independent flag group writes
      applyStimulus(4'b1110, 4'b0100, 2'b10);
      checkOutput("fw_nz", Flags, 32'h4);
      applyStimulus(4'b1110, 4'b0011, 2'b01);
      checkOutput("fw_cv", Flags, 32'h7);
      FlagW = 2'b00;

      // Conditional skip with Z=0
      loadFlags(4'b0000);
      checkOutput("clr_flags", Flags, 32'h0);
      RegW = 1'b1; MemW = 1'b1; PCS = 1'b1; NextPC = 1'b0;
      applyStimulus(4'b0000, 4'b0000, 2'b00);
      checkOutput("skip_condex", CondEx, 32'h0);
      checkOutput("skip_regwrite", RegWrite, 32'h0);
      checkOutput("skip_memwrite", MemWrite, 32'h0);
      checkOutput("skip_pcwrite", PCWrite, 32'h0);
      NextPC = 1'b1;
      #1;
      checkOutput("skip_nextpc", PCWrite, 32'h1);
      NextPC = 1'b0;
      applyStimulus(4'b0001, 4'b0000, 2'b00);
      checkOutput("pass_regwrite", RegWrite, 32'h1);
      checkOutput("pass_memwrite", MemWrite, 32'h1);
      checkOutput("pass_pcwrite", PCWrite, 32'h1);
      RegW = 1'b0; MemW = 1'b0; PCS = 1'b0;

      // Condition table, flags loaded before each entry
      for (int i = 0; i < NVEC; i++) begin
         logic [8:0] v;
         v = VECS[i];
         loadFlags(v[8:5]);
         applyStimulus(v[4:1], 4'b0000, 2'b00);
         checkOutput($sformatf("cond_%0d_f%b_c%b", i, v[8:5], v[4:1]), CondEx, {31'b0, v[0]});
      end

      // An instruction clearing its own Z still passed on the old flags
      loadFlags(4'b0100);
      applyStimulus(4'b0000, 4'b0000, 2'b11);
      checkOutput("self_flags", Flags, 32'h0);
      checkOutput("self_condex", CondEx, 32'h1);
      applyStimulus(4'b0000, 4'b0000, 2'b00);
      checkOutput("self_next_condex", CondEx, 32'h0);

      // Failed condition blocks the flag write
      applyStimulus(4'b0000, 4'b1111, 2'b11);
      checkOutput("nowrite_flags", Flags, 32'h0);
      FlagW = 2'b00;

`ifdef COND_PERF_EN
      // Retire counters: pass, fail, pass with Z=0
      fetchInstr(4'b1110);
      fetchInstr(4'b0000);
      fetchInstr(4'b0001);
      checkOutput("perf_exec", ExecCnt, 32'd2);
      checkOutput("perf_skip", SkipCnt, 32'd1);
      force dut.r_execCnt = {CNT_W{1'b1}};
      #1;
      release dut.r_execCnt;
      checkOutput("perf_preload", ExecCnt, 32'hFFFF_FFFF);
      fetchInstr(4'b1110);
      checkOutput("perf_wrap", ExecCnt, 32'd0);
      checkOutput("perf_skip_hold", SkipCnt, 32'd1);
`else
      fetchInstr(4'b1110);
      fetchInstr(4'b0000);
      checkOutput("noperf_exec", ExecCnt, 32'd0);
      checkOutput("noperf_skip", SkipCnt, 32'd0);
`endif

      // Asynchronous reset in the middle of an instruction
      loadFlags(4'b1011);
      RegW = 1'b1; MemW = 1'b1;
      applyStimulus(4'b1110, 4'b0000, 2'b00);
      checkOutput("mid_regwrite_before", RegWrite, 32'h1);
      reset = 1'b0;
      #1;
      checkOutput("mid_flags", Flags, 32'h0);
      checkOutput("mid_condex", CondEx, 32'h0);
      checkOutput("mid_regwrite", RegWrite, 32'h0);
      checkOutput("mid_memwrite", MemWrite, 32'h0);
      checkOutput("mid_exec", ExecCnt, 32'h0);
      checkOutput("mid_skip", SkipCnt, 32'h0);
      NextPC = 1'b1;
      #1;
      checkOutput("mid_nextpc", PCWrite, 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
